fp_add_normalize: RTL and testbench

Two-stage pipelined post-addition normalizer for the single-precision pipelined adder. It takes the raw 25-bit significand sum and the pre-aligned exponent from the add/subtract stage. It produces the normalized 24-bit mantissa, the updated exponent, the denormal back-shift amount and the overflow/underflow/invalid flags consumed by the final output stage. A valid bit travels with each operand, and a global hold freezes the pipeline.

---
 rtl/fp_add_normalize.sv | 158 +++++++++++++++
 tb/tb_fp_add_normalize.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_normalize.sv
// Post-addition normalizer: stage 1 counts leading zeros, stage 2 shifts and updates the exponent.
// Define NORM_LZC_PIPE_EN to register lz/carry before the shifter (latency 3 instead of 2).
module fp_add_normalize (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        hold,
    input  logic [24:0] mant_sum,
    input  logic [7:0]  exp_in,
    input  logic        sign_in,
    input  logic        invalid_in,
    output logic        out_valid,
    output logic [23:0] mantessa_mux_out,
    output logic [7:0]  E_exponent_update,
    output logic [9:0]  excessive_shift_left,
    output logic        overflow_flag,
    output logic        underflow_flag,
    output logic        invalid_flag,
    output logic        sign_out
);

    logic [24:0] r_s1_mant;
    logic [7:0]  r_s1_exp;
    logic        r_s1_sign;
    logic        r_s1_inv;
    logic        r_s1_valid;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_mant  <= '0;
            r_s1_exp   <= '0;
            r_s1_sign  <= 1'b0;
            r_s1_inv   <= 1'b0;
            r_s1_valid <= 1'b0;
        end else if (!hold) begin
            r_s1_mant  <= mant_sum;
            r_s1_exp   <= exp_in;
            r_s1_sign  <= sign_in;
            r_s1_inv   <= invalid_in;
            r_s1_valid <= in_valid;
        end
    end

    logic [4:0] w_lz;

    always_comb begin
        // NOTE: default before the loop keeps w_lz fully assigned on every path, so no latch is inferred.
        w_lz = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (r_s1_mant[i]) w_lz = 5'(23 - i);
        end
    end

    logic [24:0] w_sh_mant;
    logic [7:0]  w_sh_exp;
    logic [4:0]  w_sh_lz;
    logic        w_sh_sign;
    logic        w_sh_inv;
    logic        w_sh_valid;

`ifdef NORM_LZC_PIPE_EN
    logic [24:0] r_p_mant;
    logic [7:0]  r_p_exp;
    logic [4:0]  r_p_lz;
    logic        r_p_sign;
    logic        r_p_inv;
    logic        r_p_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_p_mant  <= '0;
            r_p_exp   <= '0;
            r_p_lz    <= '0;
            r_p_sign  <= 1'b0;
            r_p_inv   <= 1'b0;
            r_p_valid <= 1'b0;
        end else if (!hold) begin
            r_p_mant  <= r_s1_mant;
            r_p_exp   <= r_s1_exp;
            r_p_lz    <= w_lz;
            r_p_sign  <= r_s1_sign;
            r_p_inv   <= r_s1_inv;
            r_p_valid <= r_s1_valid;
        end
    end

    assign w_sh_mant  = r_p_mant;
    assign w_sh_exp   = r_p_exp;
    assign w_sh_lz    = r_p_lz;
    assign w_sh_sign  = r_p_sign;
    assign w_sh_inv   = r_p_inv;
    assign w_sh_valid = r_p_valid;
`else
    assign w_sh_mant  = r_s1_mant;
    assign w_sh_exp   = r_s1_exp;
    assign w_sh_lz    = w_lz;
    assign w_sh_sign  = r_s1_sign;
    assign w_sh_inv   = r_s1_inv;
    assign w_sh_valid = r_s1_valid;
`endif

    // Exponent math runs at 9 bits so the +1 carry and the lz borrow are visible before truncation.
    logic [8:0]  w_exp9;
    logic [8:0]  w_lz9;
    logic [8:0]  w_e9;
    logic [9:0]  w_esl;
    logic [23:0] w_mant;
    logic        w_ovf;
    logic        w_unf;

    assign w_exp9 = {1'b0, w_sh_exp};
    assign w_lz9  = {4'b0, w_sh_lz};

    always_comb begin
        w_mant = w_sh_mant[23:0] << w_sh_lz;
        w_e9   = '0;
        w_esl  = '0;
        w_ovf  = 1'b0;
        w_unf  = 1'b0;
        if (w_sh_mant[24]) begin
            w_mant = w_sh_mant[24:1];
            w_e9   = w_exp9 + 9'd1;
            w_ovf  = (w_exp9 >= 9'd254);
        end else if (w_sh_mant == 25'd0) begin
            w_mant = '0;
            w_unf  = 1'b1;
        end else if (w_lz9 < w_exp9) begin
            w_e9 = w_exp9 - w_lz9;
        end else begin
            w_unf = 1'b1;
            w_esl = {1'b0, w_lz9 - w_exp9 + 9'd1};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid            <= 1'b0;
            mantessa_mux_out     <= '0;
            E_exponent_update    <= '0;
            excessive_shift_left <= '0;
            overflow_flag        <= 1'b0;
            underflow_flag       <= 1'b0;
            invalid_flag         <= 1'b0;
            sign_out             <= 1'b0;
        end else if (!hold) begin
            out_valid            <= w_sh_valid;
            mantessa_mux_out     <= w_mant;
            E_exponent_update    <= w_e9[7:0];
            excessive_shift_left <= w_esl;
            overflow_flag        <= w_ovf & ~w_sh_inv;
            underflow_flag       <= w_unf & ~w_sh_inv;
            invalid_flag         <= w_sh_inv;
            sign_out             <= w_sh_sign;
        end
    end

endmodule

// File: tb/tb_fp_add_normalize.sv
// Self-checking bench for fp_add_normalize: directed vector table, hold/reset sequences and a
// randomized stream compared against an arithmetic reference model of the normalizer.
module tb_fp_add_normalize;

`ifdef NORM_LZC_PIPE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    typedef struct packed {
        logic [23:0] mant;
        logic [7:0]  e;
        logic [9:0]  esl;
        logic        ovf;
        logic        unf;
        logic        inv;
        logic        sign;
        logic        chk_e;
    } res_t;

    typedef struct {
        logic [24:0] mant;
        logic [7:0]  exp;
        logic        sign;
        logic        inv;
        res_t        r;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        hold;
    logic [24:0] mant_sum;
    logic [7:0]  exp_in;
    logic        sign_in;
    logic        invalid_in;
    logic        out_valid;
    logic [23:0] mantessa_mux_out;
    logic [7:0]  E_exponent_update;
    logic [9:0]  excessive_shift_left;
    logic        overflow_flag;
    logic        underflow_flag;
    logic        invalid_flag;
    logic        sign_out;

    int checks   = 0;
    int failures = 0;

    fp_add_normalize dut (
        .clk                  (clk),
        .rst                  (rst),
        .in_valid             (in_valid),
        .hold                 (hold),
        .mant_sum             (mant_sum),
        .exp_in               (exp_in),
        .sign_in              (sign_in),
        .invalid_in           (invalid_in),
        .out_valid            (out_valid),
        .mantessa_mux_out     (mantessa_mux_out),
        .E_exponent_update    (E_exponent_update),
        .excessive_shift_left (excessive_shift_left),
        .overflow_flag        (overflow_flag),
        .underflow_flag       (underflow_flag),
        .invalid_flag         (invalid_flag),
        .sign_out             (sign_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: find the leading one by measuring the sum's bit length, then apply the exponent rules.
    function automatic res_t model(input logic [24:0] m, input logic [7:0] e, input logic s,
                                   input logic inv);
        res_t r;
        int   lz;
        int   ei;
        int   v;
        r       = '0;
        r.sign  = s;
        r.inv   = inv;
        r.chk_e = 1'b1;
        ei      = int'(e);
        if (m[24]) begin
            r.mant = m[24:1];
            if (ei >= 254) begin
                r.ovf   = 1'b1;
                r.chk_e = 1'b0;
            end else begin
                r.e = 8'(ei + 1);
            end
        end else if (m == 25'd0) begin
            r.unf = 1'b1;
        end else begin
            v  = int'(m);
            lz = 24;
            while (v != 0) begin
                v  = v >> 1;
                lz = lz - 1;
            end
            r.mant = m[23:0] << lz;
            if (lz < ei) begin
                r.e = 8'(ei - lz);
            end else begin
                r.unf = 1'b1;
                r.esl = 10'(lz - ei + 1);
            end
        end
        if (inv) begin
            r.ovf = 1'b0;
            r.unf = 1'b0;
        end
        return r;
    endfunction

    function automatic vec_t mk(input logic [24:0] m, input logic [7:0] e, input logic s,
                                input logic inv, input logic [23:0] em, input logic [7:0] ee,
                                input logic [9:0] eesl, input logic eovf, input logic eunf,
                                input logic chk_e);
        vec_t v;
        v.mant    = m;
        v.exp     = e;
        v.sign    = s;
        v.inv     = inv;
        v.r.mant  = em;
        v.r.e     = ee;
        v.r.esl   = eesl;
        v.r.ovf   = eovf;
        v.r.unf   = eunf;
        v.r.inv   = inv;
        v.r.sign  = s;
        v.r.chk_e = chk_e;
        return v;
    endfunction

    task automatic check_out(input string tag, input res_t r);
        check({tag, ".mant"}, 32'(mantessa_mux_out), 32'(r.mant));
        if (r.chk_e) check({tag, ".exp"}, 32'(E_exponent_update), 32'(r.e));
        check({tag, ".esl"},  32'(excessive_shift_left), 32'(r.esl));
        check({tag, ".ovf"},  32'(overflow_flag),  32'(r.ovf));
        check({tag, ".unf"},  32'(underflow_flag), 32'(r.unf));
        check({tag, ".inv"},  32'(invalid_flag),   32'(r.inv));
        check({tag, ".sign"}, 32'(sign_out),       32'(r.sign));
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".valid"}, 32'(out_valid), 32'd0);
        check({tag, ".mant"},  32'(mantessa_mux_out), 32'd0);
        check({tag, ".exp"},   32'(E_exponent_update), 32'd0);
        check({tag, ".esl"},   32'(excessive_shift_left), 32'd0);
        check({tag, ".ovf"},   32'(overflow_flag), 32'd0);
        check({tag, ".unf"},   32'(underflow_flag), 32'd0);
        check({tag, ".inv"},   32'(invalid_flag), 32'd0);
        check({tag, ".sign"},  32'(sign_out), 32'd0);
    endtask

    task automatic drive(input logic [24:0] m, input logic [7:0] e, input logic s, input logic inv);
        mant_sum   = m;
        exp_in     = e;
        sign_in    = s;
        invalid_in = inv;
    endtask

    task automatic drive_random();
        logic [24:0] m;
        logic [7:0]  e;
        case ($urandom_range(0, 4))
            0:       m = 25'($urandom);
            1:       m = 25'($urandom >> $urandom_range(8, 31));
            2:       m = {1'b1, 24'($urandom)};
            3:       m = 25'd0;
            default: m = {1'b0, 24'($urandom)};
        endcase
        e = 8'($urandom);
        if ($urandom_range(0, 3) == 0) e = 8'($urandom_range(250, 255));
        if ($urandom_range(0, 3) == 0) e = 8'($urandom_range(0, 24));
        drive(m, e, 1'($urandom), ($urandom_range(0, 7) == 0));
    endtask

    // Model pipeline: an array shifted whenever the DUT should advance; its last slot is the expected output.
    res_t pipe [LAT];
    logic pv   [LAT];
    logic mon_en;
    logic mon_hold;
    int   out_cnt;

    always @(posedge clk) begin
        mon_hold = hold;
        if (!rst) begin
            for (int i = 0; i < LAT; i++) pv[i] = 1'b0;
        end else if (!hold) begin
            for (int i = LAT - 1; i > 0; i--) begin
                pipe[i] = pipe[i-1];
                pv[i]   = pv[i-1];
            end
            pipe[0] = model(mant_sum, exp_in, sign_in, invalid_in);
            pv[0]   = in_valid;
        end
        #1;
        if (rst && !mon_hold && out_valid) out_cnt++;
        if (mon_en && rst) begin
            check("mon.valid", 32'(out_valid), 32'(pv[LAT-1]));
            if (pv[LAT-1]) check_out("mon", pipe[LAT-1]);
        end
    end

    vec_t tbl [13];

    task automatic apply_vec(input string tag, input vec_t v);
        @(negedge clk);
        drive(v.mant, v.exp, v.sign, v.inv);
        in_valid = 1'b1;
        hold     = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (LAT - 1) @(posedge clk);
        #1;
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check_out(tag, v.r);
    endtask

    initial begin
        int cnt0;
        rst     = 1'b0;
        hold    = 1'b0;
        in_valid = 1'b0;
        mon_en  = 1'b0;
        out_cnt = 0;
        drive(25'd0, 8'd0, 1'b0, 1'b0);

        tbl[0]  = mk(25'h1000000, 8'd127, 1'b0, 1'b0, 24'h800000, 8'd128, 10'd0,  1'b0, 1'b0, 1'b1);
        tbl[1]  = mk(25'h0400000, 8'd127, 1'b0, 1'b0, 24'h800000, 8'd126, 10'd0,  1'b0, 1'b0, 1'b1);
        tbl[2]  = mk(25'h1800000, 8'd254, 1'b0, 1'b0, 24'hC00000, 8'd0,   10'd0,  1'b1, 1'b0, 1'b0);
        tbl[3]  = mk(25'h1800000, 8'd254, 1'b0, 1'b1, 24'hC00000, 8'd0,   10'd0,  1'b0, 1'b0, 1'b0);
        tbl[4]  = mk(25'h0000001, 8'd10,  1'b1, 1'b0, 24'h800000, 8'd0,   10'd14, 1'b0, 1'b1, 1'b1);
        tbl[5]  = mk(25'h0000000, 8'd100, 1'b0, 1'b0, 24'h000000, 8'd0,   10'd0,  1'b0, 1'b1, 1'b1);
        tbl[6]  = mk(25'h0000000, 8'd100, 1'b1, 1'b1, 24'h000000, 8'd0,   10'd0,  1'b0, 1'b0, 1'b1);
        tbl[7]  = mk(25'h1FFFFFF, 8'd253, 1'b1, 1'b0, 24'hFFFFFF, 8'd254, 10'd0,  1'b0, 1'b0, 1'b1);
        tbl[8]  = mk(25'h0000100, 8'd15,  1'b0, 1'b0, 24'h800000, 8'd0,   10'd1,  1'b0, 1'b1, 1'b1);
        tbl[9]  = mk(25'h0000100, 8'd16,  1'b0, 1'b0, 24'h800000, 8'd1,   10'd0,  1'b0, 1'b0, 1'b1);
        tbl[10] = mk(25'h0ABCDEF, 8'd0,   1'b0, 1'b0, 24'hABCDEF, 8'd0,   10'd1,  1'b0, 1'b1, 1'b1);
        tbl[11] = mk(25'h0ABCDEF, 8'd200, 1'b1, 1'b0, 24'hABCDEF, 8'd200, 10'd0,  1'b0, 1'b0, 1'b1);
        tbl[12] = mk(25'h1000001, 8'd255, 1'b0, 1'b0, 24'h800000, 8'd0,   10'd0,  1'b1, 1'b0, 1'b0);

        #1;
        check_zero("reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 13; i++) apply_vec($sformatf("vec%0d", i), tbl[i]);
        @(posedge clk);
        #1;
        check("valid_drop", 32'(out_valid), 32'd0);

        // Four operands with a three-cycle hold after the second one.
        mon_en = 1'b1;
        cnt0   = out_cnt;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (k >= 2 && k <= 4) begin
                hold = 1'b1;
                drive_random();
            end else begin
                hold = 1'b0;
                drive(25'h0100000 + 25'(k), 8'(100 + k), k[0], 1'b0);
            end
            in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        hold     = 1'b0;
        repeat (LAT + 2) @(negedge clk);
        check("hold.count", 32'(out_cnt - cnt0), 32'd4);

        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            drive_random();
            in_valid = ($urandom_range(0, 3) != 0);
            hold     = ($urandom_range(0, 4) == 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        hold     = 1'b0;
        repeat (LAT + 2) @(negedge clk);
        mon_en = 1'b0;

        // Reset while two operands are in flight, with hold raised at the same time.
        drive(25'h1000000, 8'd50, 1'b1, 1'b0);
        in_valid = 1'b1;
        @(negedge clk);
        drive(25'h0200000, 8'd60, 1'b1, 1'b1);
        @(posedge clk);
        #2;
        hold = 1'b1;
        rst  = 1'b0;
        #1;
        check_zero("rst_mid");
        @(posedge clk);
        @(negedge clk);
        rst      = 1'b1;
        hold     = 1'b0;
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("rst_stale%0d", k), 32'(out_valid), 32'd0);
        end
        @(negedge clk);
        drive(25'h0000C00, 8'd20, 1'b0, 1'b0);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 1; k < LAT; k++) begin
            #1;
            check($sformatf("rst_lat%0d", k), 32'(out_valid), 32'd0);
            @(posedge clk);
        end
        #1;
        check("rst_new.valid", 32'(out_valid), 32'd1);
        check_out("rst_new", model(25'h0000C00, 8'd20, 1'b0, 1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
